wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single GPR write port between in-order pipeline writeback and a long-latency unit (divider / miss-load return).
//  Long-latency results queue in a small FIFO; a per-register scoreboard tracks outstanding long-latency destinations.
//  Sits between WB stage and register file; drives rf_* and stalls for port conflicts and RAW hazards.
// PARAMETERS
//  FIFO_DEPTH  2   long-latency result queue entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive pipe grants with FIFO non-empty before FIFO is forced to win
// PORTS
//  clk           in   1   clock
//  resetn        in   1   synchronous, active-low reset
//  pipe_valid    in   1   pipeline WB has a result this cycle
//  pipe_dest     in   5   pipeline destination register
//  pipe_wdata    in   32  pipeline write data (already load-aligned)
//  pipe_pc       in   32  pc of pipeline instruction
//  pipe_stall    out  1   pipeline WB not accepted this cycle; hold inputs
//  lu_valid      in   1   long-latency result valid
//  lu_dest       in   5   long-latency destination register
//  lu_wdata      in   32  long-latency result
//  lu_pc         in   32  pc of long-latency instruction
//  lu_ready      out  1   FIFO can accept (registered, = count < FIFO_DEPTH)
//  issue_valid   in   1   long-latency op issued this cycle
//  issue_dest    in   5   its destination register
//  rs_addr       in   5   decode-stage source rs
//  rt_addr       in   5   decode-stage source rt
//  hazard_stall  out  1   decode must stall: rs/rt pending
//  rf_we         out  1   register-file write enable (registered)
//  rf_waddr      out  5   register-file write address (registered)
//  rf_wdata      out  32  register-file write data (registered)
// BEHAVIOUR
//  Reset: FIFO flushed (count 0), scoreboard all 0, starve counter 0, rf_we/rf_waddr/rf_wdata 0, lu_ready 0 for the reset cycle then 1.
//  Reset mid-operation discards queued results and pending bits; no write issued in the reset cycle or after it from old state.
//  Push: lu_valid && lu_ready -> entry {dest,wdata,pc} at tail. lu_ready from count at cycle start; a same-cycle pop never admits a push when full.
//  Grant (combinational, per cycle):
//   - FIFO empty: pipe granted if pipe_valid.
//   - FIFO non-empty, pipe_valid=0: FIFO head granted.
//   - both: pipe granted unless FIFO full or starve==STARVE_MAX; else FIFO head granted.
//  pipe_stall = pipe_valid && !pipe_granted.
//  Latency: granted source appears on rf_* one edge later; rf_we=0 in cycles with no grant.
//  dest==0: grant consumed (FIFO popped / pipe accepted) but rf_we=0.
//  Starve counter: +1 when pipe granted and FIFO non-empty; cleared when FIFO granted or FIFO empty; saturates at STARVE_MAX.
//  Scoreboard sb[31:0]: set on issue_valid with issue_dest!=0; cleared on the edge a FIFO entry with that dest is granted.
//   Same-cycle set and clear of one register: set wins. sb[0] always 0.
//  hazard_stall = (rs!=0 && (sb[rs] || (rf_we && rf_waddr==rs))) || same for rt. Combinational; no forwarding from rf_* outputs.
//  issue_valid to an already-pending register: bit stays set; single bit is sufficient because long-latency unit returns in order.
// CONFIGURATION
//  WB_ARB_DEBUG_EN defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0],
//   registered with rf_*; wen = {4{rf_we}}; pc of the granted source; reset 32'hbfc00000 / 0 / 0 / 0.
//  Undefined: ports absent; FIFO pc field and pipe_pc/lu_pc unused (tie-off allowed, no storage).
// STRUCTURE
//  Shared constants in head.h: REG_ADDR_W (5), ZERO_REG (5'd0), RESET_PC (32'hbfc00000).
//  One sub-module: wb_arb_fifo (synchronous FIFO, params WIDTH/DEPTH, push/pop/full/empty/count, resetn flush).
//  Grant logic, starve counter, scoreboard and output registers stay in wb_port_arbiter.
// TESTING
//  1. pipe only: pipe_valid=1 dest=3 wdata=0x1234 -> next cycle rf_we=1 waddr=3 wdata=0x1234, pipe_stall=0.
//  2. issue_dest=8, then rs_addr=8 -> hazard_stall=1; lu returns dest=8 0xBEEF, FIFO empty, no pipe -> rf write 8/0xBEEF next cycle; hazard_stall=1 that cycle, 0 after.
//  3. starvation: FIFO holds 1 entry, pipe_valid=1 continuous -> 4 pipe grants, 5th cycle FIFO wins, pipe_stall=1 that cycle only.
//  4. full: 2 lu pushes with pipe_valid=1 -> lu_ready=0, FIFO granted, pipe_stall=1; simultaneous pop+push attempt not accepted.
//  5. dest 0: lu dest=0 and pipe dest=0 -> entries consumed, rf_we stays 0, sb unchanged; issue_dest=0 never stalls.
//  6. resetn=0 with FIFO full and sb[5]=1 -> next cycle count 0, sb 0, rf_we 0, hazard_stall 0 for rs=5.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, grant encoding and FIFO entry layout for the writeback port arbiter.
// WB_ARB_DEBUG_EN adds a pc field to each queued long-latency entry.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [DATA_W-1:0]     RESET_PC = 32'hbfc00000;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_t;

  typedef struct packed {
`ifdef WB_ARB_DEBUG_EN
    logic [DATA_W-1:0]     pc;
`endif
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     wdata;
  } lu_entry_t;

  // A source register blocks decode while its long-latency result is pending
  // or while its write is still sitting on the register-file port.
  function automatic logic reg_pending(input logic [REG_ADDR_W-1:0] addr,
                                       input logic [31:0]           sb,
                                       input logic                  we,
                                       input logic [REG_ADDR_W-1:0] waddr);
    return (addr != ZERO_REG) && (sb[addr] || (we && (waddr == addr)));
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / long-latency unit / decode and the port arbiter.
// WB_ARB_DEBUG_EN adds the debug_wb_* trace signals.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_dest;
  logic [DATA_W-1:0]     pipe_wdata;
  logic [DATA_W-1:0]     pipe_pc;
  logic                  pipe_stall;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_dest;
  logic [DATA_W-1:0]     lu_wdata;
  logic [DATA_W-1:0]     lu_pc;
  logic                  lu_ready;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic                  hazard_stall;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
`ifdef WB_ARB_DEBUG_EN
  logic [DATA_W-1:0]     debug_wb_pc;
  logic [3:0]            debug_wb_rf_wen;
  logic [REG_ADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0]     debug_wb_rf_wdata;
`endif

  modport slave (
    input  pipe_valid, pipe_dest, pipe_wdata, pipe_pc,
    input  lu_valid, lu_dest, lu_wdata, lu_pc,
    input  issue_valid, issue_dest, rs_addr, rt_addr,
`ifdef WB_ARB_DEBUG_EN
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
`endif
    output pipe_stall, lu_ready, hazard_stall, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_valid, pipe_dest, pipe_wdata, pipe_pc,
    output lu_valid, lu_dest, lu_wdata, lu_pc,
    output issue_valid, issue_dest, rs_addr, rt_addr,
`ifdef WB_ARB_DEBUG_EN
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
`endif
    input  pipe_stall, lu_ready, hazard_stall, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Show-ahead synchronous FIFO for long-latency results; head is readable while non-empty.
// Pushes when full and pops when empty are ignored; resetn flushes pointers and count.
module wb_arb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single GPR write port between pipeline WB and queued long-latency results.
// WB_ARB_DEBUG_EN adds registered debug_wb_* trace outputs carrying the granted pc.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               resetn,
  wb_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  lu_entry_t             push_entry;
  lu_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;
  logic                  push;
  logic                  pop;
  grant_t                grant;
  logic                  lu_ready_reg;
  logic [STV_W-1:0]      starve_reg;
  logic [31:0]           sb_reg;
  logic [31:0]           sb_next;
  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0]     rf_wdata_reg;

  assign push_entry.dest  = bus.lu_dest;
  assign push_entry.wdata = bus.lu_wdata;
`ifdef WB_ARB_DEBUG_EN
  assign push_entry.pc    = bus.lu_pc;
`else
  logic unused_pc;
  assign unused_pc = ^{bus.pipe_pc, bus.lu_pc};
`endif

  assign push = bus.lu_valid && lu_ready_reg;
  assign pop  = (grant == GRANT_FIFO);

  wb_arb_fifo #(
    .WIDTH ($bits(lu_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (push_entry),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Pipe wins by default; a full queue or a starved queue takes the port instead.
  always_comb begin
    grant = GRANT_NONE;
    if (fifo_empty) begin
      if (bus.pipe_valid) grant = GRANT_PIPE;
    end else if (!bus.pipe_valid || fifo_full || (starve_reg == STV_W'(STARVE_MAX))) begin
      grant = GRANT_FIFO;
    end else begin
      grant = GRANT_PIPE;
    end
  end

  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    sb_next = sb_reg;
    if (pop && (head.dest != ZERO_REG)) sb_next[head.dest] = 1'b0;
    if (bus.issue_valid && (bus.issue_dest != ZERO_REG)) sb_next[bus.issue_dest] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lu_ready_reg <= 1'b0;
      starve_reg   <= '0;
      sb_reg       <= '0;
    end else begin
      lu_ready_reg <= (count_next < CNT_W'(FIFO_DEPTH));
      sb_reg       <= sb_next;
      if (fifo_empty || (grant == GRANT_FIFO)) begin
        starve_reg <= '0;
      end else if ((grant == GRANT_PIPE) && (starve_reg != STV_W'(STARVE_MAX))) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end
  end

  // Destination 0 still consumes the grant but never writes the register file.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      unique case (grant)
        GRANT_PIPE: begin
          rf_we_reg    <= (bus.pipe_dest != ZERO_REG);
          rf_waddr_reg <= bus.pipe_dest;
          rf_wdata_reg <= bus.pipe_wdata;
        end
        GRANT_FIFO: begin
          rf_we_reg    <= (head.dest != ZERO_REG);
          rf_waddr_reg <= head.dest;
          rf_wdata_reg <= head.wdata;
        end
        default: rf_we_reg <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_DEBUG_EN
  logic [DATA_W-1:0] debug_pc_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      debug_pc_reg <= RESET_PC;
    end else if (grant == GRANT_PIPE) begin
      debug_pc_reg <= bus.pipe_pc;
    end else if (grant == GRANT_FIFO) begin
      debug_pc_reg <= head.pc;
    end
  end

  assign bus.debug_wb_pc       = debug_pc_reg;
  assign bus.debug_wb_rf_wen   = {4{rf_we_reg}};
  assign bus.debug_wb_rf_wnum  = rf_waddr_reg;
  assign bus.debug_wb_rf_wdata = rf_wdata_reg;
`endif

  assign bus.pipe_stall   = bus.pipe_valid && (grant != GRANT_PIPE);
  assign bus.lu_ready     = lu_ready_reg;
  assign bus.rf_we        = rf_we_reg;
  assign bus.rf_waddr     = rf_waddr_reg;
  assign bus.rf_wdata     = rf_wdata_reg;
  assign bus.hazard_stall = reg_pending(bus.rs_addr, sb_reg, rf_we_reg, rf_waddr_reg) ||
                            reg_pending(bus.rt_addr, sb_reg, rf_we_reg, rf_waddr_reg);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe-only writes, RAW scoreboard, starvation,
// full-queue back-pressure, destination 0 and mid-operation reset.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   fails = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %0d %s: observed %h expected %h ok", total, tag, obs, exp);
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_valid  = 1'b0; bus.pipe_dest = '0; bus.pipe_wdata = '0; bus.pipe_pc = '0;
    bus.lu_valid    = 1'b0; bus.lu_dest   = '0; bus.lu_wdata   = '0; bus.lu_pc   = '0;
    bus.issue_valid = 1'b0; bus.issue_dest = '0;
    bus.rs_addr     = '0;   bus.rt_addr   = '0;
  endtask

  task automatic set_pipe(input logic [4:0] dest, input logic [31:0] data);
    bus.pipe_valid = 1'b1; bus.pipe_dest = dest; bus.pipe_wdata = data;
  endtask

  task automatic set_lu(input logic [4:0] dest, input logic [31:0] data);
    bus.lu_valid = 1'b1; bus.lu_dest = dest; bus.lu_wdata = data;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    tick(); tick();
    chk("reset_rf_we", bus.rf_we, 0);
    chk("reset_rf_waddr", bus.rf_waddr, 0);
    chk("reset_rf_wdata", bus.rf_wdata, 0);
    chk("reset_lu_ready", bus.lu_ready, 0);
    chk("reset_hazard", bus.hazard_stall, 0);
    resetn = 1'b1;
    tick(); tick();
    chk("post_reset_lu_ready", bus.lu_ready, 1);

    // 1: pipe only
    set_pipe(5'd3, 32'h1234);
    #1 chk("t1_pipe_stall", bus.pipe_stall, 0);
    tick();
    bus.pipe_valid = 1'b0;
    chk("t1_rf_we", bus.rf_we, 1);
    chk("t1_rf_waddr", bus.rf_waddr, 3);
    chk("t1_rf_wdata", bus.rf_wdata, 32'h1234);
    tick();
    chk("t1_rf_we_idle", bus.rf_we, 0);

    // 2: scoreboard RAW hazard on r8
    bus.issue_valid = 1'b1; bus.issue_dest = 5'd8;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs_addr = 5'd8;
    #1 chk("t2_hazard_pending", bus.hazard_stall, 1);
    set_lu(5'd8, 32'hBEEF);
    tick();
    bus.lu_valid = 1'b0;
    chk("t2_hazard_queued", bus.hazard_stall, 1);
    chk("t2_rf_we_before", bus.rf_we, 0);
    tick();
    chk("t2_rf_we", bus.rf_we, 1);
    chk("t2_rf_waddr", bus.rf_waddr, 8);
    chk("t2_rf_wdata", bus.rf_wdata, 32'hBEEF);
    chk("t2_hazard_on_port", bus.hazard_stall, 1);
    tick();
    chk("t2_hazard_clear", bus.hazard_stall, 0);
    bus.rs_addr = 5'd0;

    // 3: starvation, one queued entry against continuous pipe traffic
    set_lu(5'd9, 32'hAAAA);
    set_pipe(5'd4, 32'h100);
    #1 chk("t3_push_stall", bus.pipe_stall, 0);
    tick();
    bus.lu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.pipe_wdata = 32'h100 + 32'(i);
      #1 chk($sformatf("t3_grant%0d_stall", i), bus.pipe_stall, 0);
      chk($sformatf("t3_grant%0d_rf", i), bus.rf_wdata, 32'h100 + 32'(i - 1));
      tick();
    end
    bus.pipe_wdata = 32'h105;
    #1 chk("t3_starve_stall", bus.pipe_stall, 1);
    tick();
    chk("t3_fifo_waddr", bus.rf_waddr, 9);
    chk("t3_fifo_wdata", bus.rf_wdata, 32'hAAAA);
    chk("t3_after_stall", bus.pipe_stall, 0);
    tick();
    bus.pipe_valid = 1'b0;
    chk("t3_held_pipe_wdata", bus.rf_wdata, 32'h105);
    tick();

    // 4: queue fills while pipe keeps writing
    set_pipe(5'd6, 32'h600);
    set_lu(5'd10, 32'hA0);
    tick();
    set_pipe(5'd6, 32'h601);
    set_lu(5'd11, 32'hB0);
    #1 chk("t4_second_push_ready", bus.lu_ready, 1);
    chk("t4_second_push_stall", bus.pipe_stall, 0);
    tick();
    set_pipe(5'd6, 32'h602);
    set_lu(5'd12, 32'hC0);
    chk("t4_full_lu_ready", bus.lu_ready, 0);
    #1 chk("t4_full_pipe_stall", bus.pipe_stall, 1);
    tick();
    bus.lu_valid = 1'b0;
    chk("t4_pop_waddr", bus.rf_waddr, 10);
    chk("t4_pop_wdata", bus.rf_wdata, 32'hA0);
    chk("t4_ready_again", bus.lu_ready, 1);
    #1 chk("t4_pipe_resumes", bus.pipe_stall, 0);
    tick();
    bus.pipe_valid = 1'b0;
    chk("t4_pipe_wdata", bus.rf_wdata, 32'h602);
    tick();
    chk("t4_second_waddr", bus.rf_waddr, 11);
    chk("t4_second_wdata", bus.rf_wdata, 32'hB0);
    tick();
    chk("t4_rejected_not_queued", bus.rf_we, 0);

    // 5: destination 0 on both sources and on issue
    bus.issue_valid = 1'b1; bus.issue_dest = 5'd0;
    set_pipe(5'd0, 32'h55);
    set_lu(5'd0, 32'h66);
    #1 chk("t5_issue0_hazard", bus.hazard_stall, 0);
    tick();
    idle();
    chk("t5_pipe0_no_write", bus.rf_we, 0);
    tick();
    chk("t5_lu0_no_write", bus.rf_we, 0);
    set_pipe(5'd7, 32'h77);
    #1 chk("t5_fifo_drained", bus.pipe_stall, 0);
    tick();
    bus.pipe_valid = 1'b0;
    chk("t5_r7_write", bus.rf_waddr, 7);

    // 6: reset with a full queue and r5 pending
    bus.issue_valid = 1'b1; bus.issue_dest = 5'd5;
    set_pipe(5'd1, 32'h11);
    set_lu(5'd5, 32'h51);
    tick();
    bus.issue_valid = 1'b0;
    set_lu(5'd5, 32'h52);
    tick();
    idle();
    bus.rs_addr = 5'd5;
    chk("t6_full_lu_ready", bus.lu_ready, 0);
    #1 chk("t6_hazard_before", bus.hazard_stall, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_rf_we", bus.rf_we, 0);
    chk("t6_hazard", bus.hazard_stall, 0);
    chk("t6_lu_ready", bus.lu_ready, 0);
    set_pipe(5'd2, 32'h22);
    #1 chk("t6_fifo_flushed", bus.pipe_stall, 0);
    tick();
    bus.pipe_valid = 1'b0;
    chk("t6_new_waddr", bus.rf_waddr, 2);
    tick();
    chk("t6_no_stale_write", bus.rf_we, 0);
    chk("t6_hazard_after", bus.hazard_stall, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
